// File: rtl/sparc_rf_pkg.sv
// Shared definitions for the SPARC V8 windowed register-file spill/fill logic.
package sparc_rf_pkg;

  localparam int NWINDOWS   = 4;
  localparam int LOCAL_BASE = 16;
  localparam int NSPILL     = 16;
  localparam int DATA_W     = 32;
  localparam int WIN_W      = 2;
  localparam int MAX_WIN    = 1 << WIN_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPILL_RD,
    ST_SPILL_WR,
    ST_FILL_WAIT,
    ST_FILL_WR,
    ST_DONE
  } rf_state_e;

  // One-hot select for a window index, sized for the widest index encoding.
  function automatic logic [MAX_WIN-1:0] win_onehot(input logic [WIN_W-1:0] idx);
    logic [MAX_WIN-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/window_onehot_dec.sv
// Window index to one-hot decoder, also used by the CWP logic.
module window_onehot_dec
  import sparc_rf_pkg::*;
#(
  parameter int NWIN = NWINDOWS
) (
  input  logic [WIN_W-1:0] i_idx,
  output logic [NWIN-1:0]  o_onehot
);

  assign o_onehot = NWIN'(win_onehot(i_idx));

endmodule

// File: rtl/window_spill_fill.sv
// Register-window spill/fill engine: moves r16..r31 of one window between the
// register file and a 16-word memory frame, one word per handshake.
module window_spill_fill #(
  parameter int NWINDOWS = 4,
  parameter int DATA_W   = 32,
  parameter int NSPILL   = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                start_spill,
  input  logic                start_fill,
  input  logic [1:0]          window,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [NWINDOWS-1:0] rf_window,
  output logic [4:0]          rf_PA,
  input  logic [DATA_W-1:0]   rf_PA_out,
  output logic [4:0]          rf_PC,
  output logic [DATA_W-1:0]   rf_in,
  output logic                rf_enable,
  output logic                rf_rw,
  output logic [3:0]          mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_wvalid,
  input  logic                mem_wready,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rvalid,
  output logic                mem_rready
);

  import sparc_rf_pkg::*;

  rf_state_e           r_state;
  rf_state_e           w_next;
  logic [3:0]          r_idx;
  logic [1:0]          r_win;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rfin;
  logic                r_err;
  logic [NWINDOWS-1:0] w_winOh;
  logic                w_winBad;
  logic                w_start;
  logic                w_accept;
  logic                w_reject;
  logic                w_last;
  logic [4:0]          w_regAddr;

  window_onehot_dec #(.NWIN(NWINDOWS)) u_winDec (
    .i_idx    (r_win),
    .o_onehot (w_winOh)
  );

  assign w_winBad  = int'(window) >= NWINDOWS;
  assign w_start   = start_spill || start_fill;
  assign w_accept  = (r_state == ST_IDLE) && w_start && !w_winBad;
  assign w_reject  = (r_state == ST_IDLE) && w_start && w_winBad;
  assign w_last    = (r_idx == 4'(NSPILL - 1));
  assign w_regAddr = 5'(LOCAL_BASE) + {1'b0, r_idx};

  assign err       = r_err;
  assign rf_in     = r_rfin;
  assign mem_wdata = r_wdata;
  assign mem_addr  = r_idx;
  assign rf_window = busy ? w_winOh : NWINDOWS'(1);

  // State register; reset drops straight back to IDLE so no handshake or write survives.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus the per-state register-file and memory strobes.
  always_comb begin
    w_next     = r_state;
    busy       = 1'b1;
    done       = 1'b0;
    rf_PA      = '0;
    rf_PC      = '0;
    rf_enable  = 1'b0;
    rf_rw      = 1'b0;
    mem_wvalid = 1'b0;
    mem_rready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (w_accept) begin
          w_next = start_spill ? ST_SPILL_RD : ST_FILL_WAIT;
        end
      end
      ST_SPILL_RD: begin
        rf_PA  = w_regAddr;
        w_next = ST_SPILL_WR;
      end
      ST_SPILL_WR: begin
        mem_wvalid = 1'b1;
        if (mem_wready) begin
          w_next = w_last ? ST_DONE : ST_SPILL_RD;
        end
      end
      ST_FILL_WAIT: begin
        mem_rready = 1'b1;
        if (mem_rvalid) begin
          w_next = ST_FILL_WR;
        end
      end
      ST_FILL_WR: begin
        rf_PC     = w_regAddr;
        rf_enable = 1'b1;
        rf_rw     = 1'b1;
        w_next    = w_last ? ST_DONE : ST_FILL_WAIT;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Word counter, latched window and the two data holding registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_idx   <= '0;
      r_win   <= '0;
      r_wdata <= '0;
      r_rfin  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_reject;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_win <= window;
            r_idx <= '0;
          end
        end
        ST_SPILL_RD: begin
          r_wdata <= rf_PA_out;
        end
        ST_SPILL_WR: begin
          if (mem_wready && !w_last) begin
            r_idx <= r_idx + 4'd1;
          end
        end
        ST_FILL_WAIT: begin
          if (mem_rvalid) begin
            r_rfin <= mem_rdata;
          end
        end
        ST_FILL_WR: begin
          if (!w_last) begin
            r_idx <= r_idx + 4'd1;
          end
        end
        ST_DONE: begin
          r_idx <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_window_spill_fill.sv
// Self-checking bench for window_spill_fill with a register-file and memory model.
module tb_window_spill_fill;

  localparam int NW = 3;

  typedef struct {
    bit         sp;
    bit         fi;
    logic [1:0] w;
    bit         expErr;
    int         expLat;
  } vec_t;

  logic          Clk         = 1'b0;
  logic          Reset       = 1'b1;
  logic          start_spill = 1'b0;
  logic          start_fill  = 1'b0;
  logic [1:0]    window      = '0;
  logic          busy, done, err;
  logic [NW-1:0] rf_window;
  logic [4:0]    rf_PA, rf_PC;
  logic [31:0]   rf_PA_out, rf_in, mem_wdata;
  logic [31:0]   mem_rdata   = '0;
  logic          rf_enable, rf_rw, mem_wvalid, mem_rready;
  logic          mem_wready  = 1'b1;
  logic          mem_rvalid  = 1'b1;
  logic [3:0]    mem_addr;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rfm     [0:3][0:31];
  logic [31:0] refRf   [0:3][0:31];
  logic [31:0] fillBuf [0:15];
  logic        loadAll = 1'b0;
  logic [35:0] spillQ [$];
  int          stallCnt  = 0;
  int          rreadyCnt = 0;
  int          bpMode    = 0;
  int          stallAddr = 0;
  int          stallLeft = 0;
  logic [31:0] stallExp  = '0;

  window_spill_fill #(.NWINDOWS(NW), .DATA_W(32), .NSPILL(16)) dut (
    .Clk(Clk), .Reset(Reset), .start_spill(start_spill), .start_fill(start_fill),
    .window(window), .busy(busy), .done(done), .err(err), .rf_window(rf_window),
    .rf_PA(rf_PA), .rf_PA_out(rf_PA_out), .rf_PC(rf_PC), .rf_in(rf_in),
    .rf_enable(rf_enable), .rf_rw(rf_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready)
  );

  always #5 Clk = ~Clk;

  function automatic int decodeWin(input logic [NW-1:0] oh);
    for (int i = 0; i < NW; i++) if (oh[i] === 1'b1) return i;
    return 0;
  endfunction

  // Register file: combinational port A, port C written at the edge.
  always_comb rf_PA_out = rfm[decodeWin(rf_window)][rf_PA];

  // Register-file write port, bulk preload, and memory-side recording.
  always @(posedge Clk) begin
    if (loadAll) begin
      for (int w = 0; w < 4; w++) for (int r = 0; r < 32; r++) rfm[w][r] <= refRf[w][r];
    end else if (rf_enable && rf_rw) begin
      rfm[decodeWin(rf_window)][rf_PC] <= rf_in;
    end
    if (mem_wvalid && mem_wready) spillQ.push_back({mem_addr, mem_wdata});
    if ((mem_wvalid && !mem_wready) || (mem_rready && !mem_rvalid)) stallCnt <= stallCnt + 1;
    if (mem_rready) rreadyCnt <= rreadyCnt + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: fill data by frame offset, optional backpressure.
  initial begin
    forever begin
      @(negedge Clk);
      mem_rdata = fillBuf[mem_addr];
      case (bpMode)
        1: begin
          mem_wready = ($urandom_range(0, 2) != 0);
          mem_rvalid = ($urandom_range(0, 2) != 0);
        end
        2: begin
          mem_rvalid = 1'b1;
          if (mem_wvalid && int'(mem_addr) == stallAddr && stallLeft > 0) begin
            mem_wready = 1'b0;
            stallLeft--;
            checkOutput("stallDataHeld", mem_wdata, stallExp);
          end else begin
            mem_wready = 1'b1;
          end
        end
        default: begin
          mem_wready = 1'b1;
          mem_rvalid = 1'b1;
        end
      endcase
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ctrl"}, 32'({busy, done, err, rf_enable, rf_rw, mem_wvalid, mem_rready}), 32'd0);
    checkOutput({tag, "_rfWindow"}, 32'(rf_window), 32'd1);
    checkOutput({tag, "_addrs"}, 32'({rf_PA, rf_PC, mem_addr}), 32'd0);
    checkOutput({tag, "_rfIn"}, rf_in, 32'd0);
    checkOutput({tag, "_wdata"}, mem_wdata, 32'd0);
  endtask

  task automatic applyStimulus(input bit sp, input bit fi, input logic [1:0] w, input int midFillAt,
                               output int lat, output bit sawErr,
                               output int qBase, output int stallBase, output int rrBase);
    int cycle;
    int winBad;
    logic [NW-1:0] expOh;
    expOh = NW'(1) << w;
    lat   = 0;
    @(negedge Clk);
    qBase = spillQ.size(); stallBase = stallCnt; rrBase = rreadyCnt;
    start_spill = sp; start_fill = fi; window = w;
    @(negedge Clk);
    start_spill = 1'b0; start_fill = 1'b0; window = 2'($urandom_range(0, 3));
    cycle  = 1;
    winBad = 0;
    sawErr = err;
    if (sawErr) begin
      checkOutput("errBusy", 32'(busy), 32'd0);
      @(negedge Clk);
      checkOutput("errPulseLen", 32'(err), 32'd0);
      checkOutput("errStillIdle", 32'(busy), 32'd0);
      return;
    end
    while (!done && cycle < 600) begin
      if (busy && rf_window !== expOh) winBad++;
      start_fill = (cycle == midFillAt);
      @(negedge Clk);
      cycle++;
    end
    start_fill = 1'b0;
    checkOutput("doneSeen", 32'(done), 32'd1);
    checkOutput("rfWindowOneHot", winBad, 0);
    lat = cycle;
    @(negedge Clk);
    checkOutput("idleAfterDone", 32'({busy, done, rf_window}), 32'({2'b00, NW'(1)}));
  endtask

  // Reference: a spill streams the window's locals/ins in order, a fill overwrites them.
  task automatic verifyOp(input bit sp, input logic [1:0] w, input int lat,
                          input int qBase, input int stallBase, input int rrBase);
    int diffs;
    if (sp) begin
      checkOutput("spillWordCount", spillQ.size() - qBase, 16);
      for (int k = 0; k < 16; k++) begin
        if (qBase + k < spillQ.size()) begin
          checkOutput($sformatf("spillAddr%0d", k), 32'(spillQ[qBase + k][35:32]), k);
          checkOutput($sformatf("spillData%0d", k), spillQ[qBase + k][31:0], refRf[w][16 + k]);
        end
      end
      checkOutput("noFillHandshake", rreadyCnt - rrBase, 0);
    end else begin
      for (int k = 0; k < 16; k++) refRf[w][16 + k] = fillBuf[k];
    end
    diffs = 0;
    for (int ww = 0; ww < 4; ww++)
      for (int r = 0; r < 32; r++) if (rfm[ww][r] !== refRf[ww][r]) diffs++;
    checkOutput("rfContents", diffs, 0);
    checkOutput("latency", lat, 33 + stallCnt - stallBase);
  endtask

  initial begin
    vec_t vecs [7];
    int   lat, qb, sb, rb, cnt, diffs, kind;
    bit   sawErr, sp, fi;
    logic [1:0] w;

    vecs[0] = '{1'b1, 1'b0, 2'd1, 1'b0, 33};
    vecs[1] = '{1'b0, 1'b1, 2'd2, 1'b0, 33};
    vecs[2] = '{1'b1, 1'b0, 2'd2, 1'b0, 33};
    vecs[3] = '{1'b1, 1'b1, 2'd1, 1'b0, 33};
    vecs[4] = '{1'b1, 1'b0, 2'd3, 1'b1, 0};
    vecs[5] = '{1'b0, 1'b1, 2'd3, 1'b1, 0};
    vecs[6] = '{1'b1, 1'b0, 2'd0, 1'b0, 33};

    for (int ww = 0; ww < 4; ww++) for (int r = 0; r < 32; r++) refRf[ww][r] = $urandom;
    for (int k = 0; k < 16; k++) refRf[1][16 + k] = 100 + k;
    for (int k = 0; k < 16; k++) fillBuf[k] = 200 + k;

    Reset   = 1'b1;
    loadAll = 1'b1;
    repeat (3) @(negedge Clk);
    loadAll = 1'b0;
    checkResetState("reset");
    Reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].sp, vecs[i].fi, vecs[i].w, -1, lat, sawErr, qb, sb, rb);
      checkOutput($sformatf("vec%0d_err", i), 32'(sawErr), 32'(vecs[i].expErr));
      if (!vecs[i].expErr && !sawErr) begin
        checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].expLat);
        verifyOp(vecs[i].sp, vecs[i].w, lat, qb, sb, rb);
      end
    end

    bpMode    = 2;
    stallAddr = 5;
    stallLeft = 3;
    stallExp  = 32'd105;
    applyStimulus(1'b1, 1'b0, 2'd1, -1, lat, sawErr, qb, sb, rb);
    checkOutput("stallLatency", lat, 36);
    checkOutput("stallsConsumed", stallLeft, 0);
    verifyOp(1'b1, 2'd1, lat, qb, sb, rb);
    bpMode = 0;

    applyStimulus(1'b1, 1'b0, 2'd1, 12, lat, sawErr, qb, sb, rb);
    checkOutput("busyFillIgnoredLatency", lat, 33);
    verifyOp(1'b1, 2'd1, lat, qb, sb, rb);

    for (int k = 0; k < 16; k++) fillBuf[k] = 300 + k;
    @(negedge Clk);
    start_fill = 1'b1; window = 2'd2;
    @(negedge Clk);
    start_fill = 1'b0;
    cnt = 0;
    while (!(mem_rready && mem_addr == 4'd7) && cnt < 200) begin
      @(negedge Clk);
      cnt++;
    end
    checkOutput("reachedFillWord7", 32'(mem_rready && mem_addr == 4'd7), 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    checkResetState("midReset");
    Reset = 1'b0;
    for (int k = 0; k < 7; k++) refRf[2][16 + k] = fillBuf[k];
    checkOutput("r23Untouched", rfm[2][23], 32'd207);
    diffs = 0;
    for (int ww = 0; ww < 4; ww++)
      for (int r = 0; r < 32; r++) if (rfm[ww][r] !== refRf[ww][r]) diffs++;
    checkOutput("midResetRfContents", diffs, 0);

    bpMode = 1;
    for (int n = 0; n < 12; n++) begin
      kind = $urandom_range(0, 2);
      sp   = (kind != 1);
      fi   = (kind != 0);
      w    = 2'($urandom_range(0, 3));
      for (int k = 0; k < 16; k++) fillBuf[k] = $urandom;
      applyStimulus(sp, fi, w, -1, lat, sawErr, qb, sb, rb);
      checkOutput("randErr", 32'(sawErr), 32'(int'(w) >= NW));
      if (!sawErr && int'(w) < NW) verifyOp(sp, w, lat, qb, sb, rb);
    end
    bpMode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
